// File: rtl/cache_nway_plru.sv
// N-way set-associative write-back L1 with 256-bit lines, tree pseudo-LRU
// replacement, invalid-way-first allocation and a full-cache flush walker.
module cache_nway_plru #(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_byte_enable256,
  input  logic [255:0] mem_wdata256,
  output logic [255:0] mem_rdata256,
  output logic         mem_resp,
  input  logic         flush,
  output logic         flush_done,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);
  // state     | meaning
  // IDLE      | waiting for a request or a (pending) flush
  // LOOKUP    | tag compare; hit completes, miss picks a victim
  // WRITEBACK | dirty victim written to pmem
  // FILL      | missing line read from pmem into the victim way
  // FL_SCAN   | flush walker inspects one set/way entry per cycle
  // FL_WB     | flush walker writes back the current dirty entry
  localparam int IDX   = $clog2(SETS);
  localparam int TAGW  = 27 - IDX;
  localparam int LW    = $clog2(WAYS);
  localparam int NODES = WAYS - 1;
  localparam int SW    = IDX + LW;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITEBACK, FILL, FL_SCAN, FL_WB
  } state_t;

  state_t state_q, state_d;

  logic [255:0]     data_q  [SETS][WAYS];
  logic [TAGW-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [NODES-1:0] plru_q  [SETS];

  logic [LW-1:0] victim_q;
  logic [SW-1:0] scan_q;
  logic          flush_pend_q;

  logic [IDX-1:0]  req_idx;
  logic [TAGW-1:0] req_tag;
  logic            req;
  logic            unused_offset;

  assign req_idx       = mem_address[4+IDX:5];
  assign req_tag       = mem_address[31:5+IDX];
  assign req           = mem_read | mem_write;
  assign unused_offset = ^mem_address[4:0];

  logic [IDX-1:0] scan_set;
  logic [LW-1:0]  scan_way;
  logic           scan_last;
  logic           scan_dirty;

  assign scan_set   = scan_q[SW-1:LW];
  assign scan_way   = scan_q[LW-1:0];
  assign scan_last  = &scan_q;
  assign scan_dirty = valid_q[scan_set][scan_way] & dirty_q[scan_set][scan_way];

  // Each node on the accessed way's path is pointed at the opposite half.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                  input logic [LW-1:0]    way);
    logic [NODES-1:0] res;
    int node;
    res  = bits;
    node = 0;
    for (int l = 0; l < LW; l++) begin
      res[node] = ~way[LW-1-l];
      node      = 2 * node + 1 + int'(way[LW-1-l]);
    end
    return res;
  endfunction

  function automatic logic [LW-1:0] plru_victim(input logic [NODES-1:0] bits);
    logic [LW-1:0] v;
    int node;
    v    = '0;
    node = 0;
    for (int l = 0; l < LW; l++) begin
      v[LW-1-l] = bits[node];
      node      = 2 * node + 1 + int'(bits[node]);
    end
    return v;
  endfunction

  logic          hit;
  logic [LW-1:0] hit_way;
  logic          has_inv;
  logic [LW-1:0] inv_way;
  logic [LW-1:0] victim_way;
  logic [255:0]  hit_line;
  logic [255:0]  merged_line;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = LW'(w);
      end
    end
  end

  always_comb begin
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        has_inv = 1'b1;
        inv_way = LW'(w);
      end
    end
  end

  assign victim_way = has_inv ? inv_way : plru_victim(plru_q[req_idx]);
  assign hit_line   = data_q[req_idx][hit_way];

  always_comb begin
    merged_line = hit_line;
    for (int b = 0; b < 32; b++) begin
      if (mem_byte_enable256[b]) merged_line[8*b +: 8] = mem_wdata256[8*b +: 8];
    end
  end

  logic lookup_hit, lookup_miss, fill_done, fl_wb_done;
  logic flush_start, scan_adv, scan_end;

  assign lookup_hit  = (state_q == LOOKUP) && req && hit;
  assign lookup_miss = (state_q == LOOKUP) && req && !hit;
  assign fill_done   = (state_q == FILL) && pmem_resp;
  assign fl_wb_done  = (state_q == FL_WB) && pmem_resp;

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    mem_rdata256 = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    flush_start  = 1'b0;
    scan_adv     = 1'b0;
    scan_end     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOOKUP;
        end else if (flush || flush_pend_q) begin
          state_d     = FL_SCAN;
          flush_start = 1'b1;
        end
      end
      LOOKUP: begin
        if (!req) begin
          state_d = IDLE;
        end else if (hit) begin
          mem_resp = 1'b1;
          if (!mem_write) mem_rdata256 = hit_line;
          state_d = IDLE;
        end else if (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) begin
          state_d = WRITEBACK;
        end else begin
          state_d = FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[req_idx][victim_q], req_idx, 5'b0};
        pmem_wdata   = data_q[req_idx][victim_q];
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_idx, 5'b0};
        if (pmem_resp) state_d = LOOKUP;
      end
      FL_SCAN: begin
        if (scan_dirty) begin
          state_d = FL_WB;
        end else if (scan_last) begin
          scan_end = 1'b1;
          state_d  = IDLE;
        end else begin
          scan_adv = 1'b1;
        end
      end
      FL_WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[scan_set][scan_way], scan_set, 5'b0};
        pmem_wdata   = data_q[scan_set][scan_way];
        if (pmem_resp) begin
          if (scan_last) begin
            scan_end = 1'b1;
            state_d  = IDLE;
          end else begin
            scan_adv = 1'b1;
            state_d  = FL_SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      victim_q     <= '0;
      scan_q       <= '0;
      flush_pend_q <= 1'b0;
      flush_done   <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      flush_done <= scan_end;
      // A flush that cannot start right away is remembered until IDLE.
      if (flush_start)  flush_pend_q <= 1'b0;
      else if (flush)   flush_pend_q <= 1'b1;
      if (lookup_hit) begin
        plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
        if (mem_write) dirty_q[req_idx][hit_way] <= 1'b1;
      end
      if (lookup_miss) victim_q <= victim_way;
      if (fill_done) begin
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= 1'b0;
      end
      if (fl_wb_done) dirty_q[scan_set][scan_way] <= 1'b0;
      if (flush_start)   scan_q <= '0;
      else if (scan_adv) scan_q <= scan_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (lookup_hit && mem_write) data_q[req_idx][hit_way] <= merged_line;
    if (fill_done) begin
      data_q[req_idx][victim_q] <= pmem_rdata;
      tag_q[req_idx][victim_q]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_cache_nway_plru.sv
// Scoreboard bench for cache_nway_plru: read data checked against an
// architectural memory model, pmem traffic logged and checked for order.
module tb_cache_nway_plru;
  typedef struct packed {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // default-parameter instance
  logic         rst, mem_read, mem_write, mem_resp, flush, flush_done;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [31:0]  mem_address, mem_be, pmem_address;
  logic [255:0] mem_wdata, mem_rdata, pmem_wdata, pmem_rdata;

  // WAYS=8, SETS=16 instance
  logic         b_rst, b_mem_read, b_mem_write, b_mem_resp, b_flush, b_flush_done;
  logic         b_pmem_read, b_pmem_write, b_pmem_resp;
  logic [31:0]  b_mem_address, b_mem_be, b_pmem_address;
  logic [255:0] b_mem_wdata, b_mem_rdata, b_pmem_wdata, b_pmem_rdata;

  cache_nway_plru #(.WAYS(4), .SETS(8)) dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable256(mem_be), .mem_wdata256(mem_wdata),
    .mem_rdata256(mem_rdata), .mem_resp(mem_resp), .flush(flush), .flush_done(flush_done),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  cache_nway_plru #(.WAYS(8), .SETS(16)) dut_b (
    .clk(clk), .rst(b_rst), .mem_address(b_mem_address), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_byte_enable256(b_mem_be), .mem_wdata256(b_mem_wdata),
    .mem_rdata256(b_mem_rdata), .mem_resp(b_mem_resp), .flush(b_flush), .flush_done(b_flush_done),
    .pmem_address(b_pmem_address), .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
    .pmem_wdata(b_pmem_wdata), .pmem_rdata(b_pmem_rdata), .pmem_resp(b_pmem_resp)
  );

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int pm_wait = 0;
  int b_wait = 0;
  int b_rd_cnt = 0;

  logic [255:0] exp_q[$];
  txn_t         log_q[$];
  logic [255:0] shadow  [logic [26:0]];
  logic [255:0] backing [logic [26:0]];

  task automatic chk_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [26:0] ln);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = {ln[23:0], 8'(i)} ^ 32'h5A3C_0000;
    return r;
  endfunction

  function automatic logic [255:0] mem_val(input logic [26:0] ln);
    return backing.exists(ln) ? backing[ln] : init_line(ln);
  endfunction

  function automatic logic [255:0] arch(input logic [26:0] ln);
    return shadow.exists(ln) ? shadow[ln] : mem_val(ln);
  endfunction

  // pmem responder for the default instance: answers after three idle cycles
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        pm_wait   = 0;
      end else if (pmem_read || pmem_write) begin
        if (pm_wait == 2) begin
          chk_val("pm_excl", 256'(pmem_read & pmem_write), 256'(0));
          chk_val("pm_align", 256'(pmem_address[4:0]), 256'(0));
          if (pmem_write) begin
            chk_val("wb_data", pmem_wdata, arch(pmem_address[31:5]));
            backing[pmem_address[31:5]] = pmem_wdata;
            log_q.push_back('{wr: 1'b1, addr: pmem_address, data: pmem_wdata});
          end else begin
            pmem_rdata = mem_val(pmem_address[31:5]);
            log_q.push_back('{wr: 1'b0, addr: pmem_address, data: pmem_rdata});
          end
          pmem_resp = 1'b1;
        end else begin
          pm_wait++;
        end
      end else begin
        pm_wait = 0;
      end
    end
  end

  initial begin
    b_pmem_resp  = 1'b0;
    b_pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (b_pmem_resp) begin
        b_pmem_resp = 1'b0;
        b_wait      = 0;
      end else if (b_pmem_read || b_pmem_write) begin
        if (b_wait == 2) begin
          b_pmem_rdata = init_line(b_pmem_address[31:5]);
          if (b_pmem_read) b_rd_cnt++;
          b_pmem_resp = 1'b1;
        end else begin
          b_wait++;
        end
      end else begin
        b_wait = 0;
      end
    end
  end

  always @(negedge clk) if (flush_done) done_cnt++;

  task automatic access(input logic [31:0] addr, input logic wr, input logic [31:0] be,
                        input logic [255:0] wd, output int lat);
    logic [26:0]  ln;
    logic [255:0] cur, nxt;
    ln  = addr[31:5];
    cur = arch(ln);
    nxt = cur;
    if (wr) begin
      for (int b = 0; b < 32; b++) if (be[b]) nxt[8*b +: 8] = wd[8*b +: 8];
      shadow[ln] = nxt;
    end else begin
      exp_q.push_back(cur);
    end
    mem_address = addr;
    mem_read    = !wr;
    mem_write   = wr;
    mem_be      = be;
    mem_wdata   = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_resp && lat < 300);
    if (!mem_resp) begin
      chk_val("resp_timeout", 256'(0), 256'(1));
      if (!wr) void'(exp_q.pop_back());
    end else if (!wr) begin
      chk_val("rdata", mem_rdata, exp_q.pop_front());
    end
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output int lat);
    access(addr, 1'b0, 32'h0, 256'h0, lat);
  endtask

  task automatic b_access(input logic [31:0] addr, output int lat);
    exp_q.push_back(init_line(addr[31:5]));
    b_mem_address = addr;
    b_mem_read    = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!b_mem_resp && lat < 300);
    if (!b_mem_resp) begin
      chk_val("b_resp_timeout", 256'(0), 256'(1));
      void'(exp_q.pop_back());
    end else begin
      chk_val("b_rdata", b_mem_rdata, exp_q.pop_front());
    end
    @(negedge clk);
    b_mem_read = 1'b0;
  endtask

  task automatic do_flush(output int lat);
    flush = 1'b1;
    lat   = 0;
    do begin
      @(negedge clk);
      flush = 1'b0;
      lat++;
    end while (!flush_done && lat < 400);
    if (!flush_done) chk_val("flush_timeout", 256'(0), 256'(1));
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    shadow.delete();
    @(negedge clk);
  endtask

  initial begin
    int lat, n, k;
    rst = 1'b0; b_rst = 1'b0;
    mem_address = '0; mem_read = 1'b0; mem_write = 1'b0; mem_be = '0; mem_wdata = '0; flush = 1'b0;
    b_mem_address = '0; b_mem_read = 1'b0; b_mem_write = 1'b0; b_mem_be = '0; b_mem_wdata = '0;
    b_flush = 1'b0;
    repeat (2) @(negedge clk);
    chk_val("rst_mem_resp", 256'(mem_resp), 256'(0));
    chk_val("rst_flush_done", 256'(flush_done), 256'(0));
    chk_val("rst_pmem_read", 256'(pmem_read), 256'(0));
    chk_val("rst_pmem_write", 256'(pmem_write), 256'(0));
    chk_val("rst_pmem_addr", 256'(pmem_address), 256'(0));
    chk_val("rst_pmem_wdata", pmem_wdata, 256'(0));
    chk_val("rst_rdata", mem_rdata, 256'(0));
    rst = 1'b1;
    @(negedge clk);

    // cold read, then hit with no pmem traffic
    log_q.delete();
    rd(32'h0000_1040, lat);
    chk_val("cold_n", 256'(log_q.size()), 256'(1));
    if (log_q.size() >= 1) begin
      chk_val("cold_wr", 256'(log_q[0].wr), 256'(0));
      chk_val("cold_addr", 256'(log_q[0].addr), 256'(32'h0000_1040));
    end
    rd(32'h0000_1040, lat);
    chk_val("hit_lat", 256'(lat), 256'(1));
    chk_val("hit_no_pmem", 256'(log_q.size()), 256'(1));
    access(32'h0000_1040, 1'b1, 32'hF000_0000, {32'h1122_3344, 224'h0}, lat);
    chk_val("whit_lat", 256'(lat), 256'(1));
    rd(32'h0000_1040, lat);

    // write merge, PLRU victim, dirty write-back before fill
    rd(32'h0000_0000, lat);
    access(32'h0000_0000, 1'b1, 32'h0000_000F, 256'hAABB_CCDD, lat);
    chk_val("wmerge_lat", 256'(lat), 256'(1));
    rd(32'h0000_0100, lat);
    rd(32'h0000_0200, lat);
    rd(32'h0000_0300, lat);
    log_q.delete();
    rd(32'h0000_0400, lat);
    chk_val("evict_n", 256'(log_q.size()), 256'(2));
    if (log_q.size() >= 2) begin
      chk_val("evict_wr0", 256'(log_q[0].wr), 256'(1));
      chk_val("evict_addr0", 256'(log_q[0].addr), 256'(0));
      chk_val("evict_low", 256'(log_q[0].data[31:0]), 256'(32'hAABB_CCDD));
      chk_val("evict_rest", 256'(log_q[0].data[255:32]), 256'(init_line(27'h0) >> 32));
      chk_val("evict_wr1", 256'(log_q[1].wr), 256'(0));
      chk_val("evict_addr1", 256'(log_q[1].addr), 256'(32'h0000_0400));
    end
    rd(32'h0000_0100, lat);
    chk_val("plru_keep", 256'(lat), 256'(1));
    n = log_q.size();
    rd(32'h0000_0000, lat);
    chk_val("plru_gone", 256'(log_q.size()), 256'(n + 1));

    // flush timing with nothing dirty
    reset_dut();
    done_cnt = 0;
    do_flush(lat);
    chk_val("flush_lat", 256'(lat), 256'(33));

    // flush with dirty set2/way1 and set5/way3
    rd(32'h0000_0040, lat);
    access(32'h0000_0140, 1'b1, 32'h0000_00F0, 256'h1234_5678 << 128, lat);
    rd(32'h0000_00A0, lat);
    rd(32'h0000_01A0, lat);
    rd(32'h0000_02A0, lat);
    access(32'h0000_03A0, 1'b1, 32'hFF00_0000, {8{32'hCAFE_F00D}}, lat);
    log_q.delete();
    done_cnt = 0;
    do_flush(lat);
    repeat (3) @(negedge clk);
    chk_val("flush_n", 256'(log_q.size()), 256'(2));
    if (log_q.size() >= 2) begin
      chk_val("flush_addr0", 256'({log_q[0].wr, log_q[0].addr}), 256'({1'b1, 32'h0000_0140}));
      chk_val("flush_addr1", 256'({log_q[1].wr, log_q[1].addr}), 256'({1'b1, 32'h0000_03A0}));
    end
    chk_val("flush_pulses", 256'(done_cnt), 256'(1));
    log_q.delete();
    rd(32'h0000_0140, lat);
    chk_val("post_flush_hit0", 256'(lat), 256'(1));
    rd(32'h0000_03A0, lat);
    chk_val("post_flush_hit1", 256'(lat), 256'(1));
    chk_val("post_flush_quiet", 256'(log_q.size()), 256'(0));

    // flush arriving with a request is deferred, request served first
    access(32'h0000_0140, 1'b1, 32'h0000_0001, 256'h77, lat);
    log_q.delete();
    done_cnt = 0;
    fork
      begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join_none
    rd(32'h0000_0040, lat);
    chk_val("defer_hit_lat", 256'(lat), 256'(1));
    k = 0;
    while (done_cnt == 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk_val("defer_flush_done", 256'(done_cnt), 256'(1));
    chk_val("defer_wb_n", 256'(log_q.size()), 256'(1));

    // reset mid-fill drops pmem_read without a clock edge
    mem_address = 32'h0000_2000;
    mem_read    = 1'b1;
    k = 0;
    while (!pmem_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk_val("midfill_seen", 256'(pmem_read), 256'(1));
    #1 rst = 1'b0;
    #1;
    chk_val("midfill_rd_drop", 256'(pmem_read), 256'(0));
    chk_val("midfill_addr_zero", 256'(pmem_address), 256'(0));
    mem_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    shadow.delete();
    @(negedge clk);
    log_q.delete();
    rd(32'h0000_0040, lat);
    chk_val("post_rst_miss", 256'(log_q.size()), 256'(1));

    // WAYS=8, SETS=16: fill one set, PLRU victim, mid-fill reset
    b_rst = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 8; w++) b_access(32'(w) << 9, lat);
    chk_val("b_fill_reads", 256'(b_rd_cnt), 256'(8));
    b_access(32'h0000_1000, lat);
    b_access(32'h0000_0200, lat);
    chk_val("b_plru_keep", 256'(lat), 256'(1));
    n = b_rd_cnt;
    b_access(32'h0000_0000, lat);
    chk_val("b_plru_gone", 256'(b_rd_cnt), 256'(n + 1));
    b_mem_address = 32'h0000_3000;
    b_mem_read    = 1'b1;
    k = 0;
    while (!b_pmem_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk_val("b_midfill_seen", 256'(b_pmem_read), 256'(1));
    #1 b_rst = 1'b0;
    #1;
    chk_val("b_midfill_drop", 256'(b_pmem_read), 256'(0));
    b_mem_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    b_rst = 1'b1;
    @(negedge clk);
    n = b_rd_cnt;
    b_access(32'h0000_0200, lat);
    chk_val("b_post_rst_miss", 256'(b_rd_cnt), 256'(n + 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
